mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares one single-ported unified memory between the instruction fetch path and the MEM-stage load/store path of the 5-stage RISC-V pipeline.
- Grants one requester at a time and drives a variable-latency req/ack memory port.
- Returns read data with a one-cycle valid pulse and generates the fetch and MEM stall signals consumed by hazard detection.
- Data accesses have priority; a starvation guard ensures fetch always makes progress.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width (byte enables are DATA_W/8 bits)
- STARVE_LIM, 4, consecutive data grants allowed while fetch is waiting before fetch is forced to win
- MAX_WAIT, 255, cycles in BUSY without m_ack before the transaction times out

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- if_req  in  1  fetch request, held high until if_valid
- if_addr  in  ADDR_W  fetch address
- if_rdata  out  DATA_W  fetched instruction
- if_valid  out  1  fetch done, one-cycle pulse
- d_req  in  1  data request, held high until d_valid
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_be  in  DATA_W/8  byte enables
- d_rdata  out  DATA_W  load data
- d_valid  out  1  data done, one-cycle pulse
- m_req  out  1  memory request
- m_we  out  1  memory write enable
- m_addr  out  ADDR_W  memory address
- m_wdata  out  DATA_W  memory write data
- m_be  out  DATA_W/8  memory byte enables
- m_ack  in  1  memory done; m_rdata is valid in this cycle
- m_rdata  in  DATA_W  memory read data
- stall_IF  out  1  if_req & ~if_valid (combinational)
- stall_MEM  out  1  d_req & ~d_valid (combinational)
- err  out  1  sticky timeout flag

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE.
  - All registered outputs go to 0: m_req, m_we, m_addr, m_wdata, m_be, if_rdata, d_rdata, if_valid, d_valid, err.
  - Starve counter and wait counter clear.
  - Any in-flight transaction is abandoned with no valid pulse.
- FSM states: IDLE, BUSY_IF, BUSY_D, RESP.
- IDLE grant decision:
  - If d_req and not (if_req and starve==STARVE_LIM): grant data, latch d_* into m_*, go to BUSY_D.
  - Else if if_req: grant fetch, latch if_addr into m_addr with m_we=0 and m_be all ones, go to BUSY_IF.
  - Else stay in IDLE.
- Starve counter:
  - Increments (saturating at STARVE_LIM) on each data grant made while if_req is high.
  - Clears on any fetch grant, and on any data grant made while if_req is low.
- m_req and m_* are registered:
  - Grant sampled at edge N → m_req=1 from cycle N+1.
  - m_* stay stable until m_ack.
- In BUSY_x, m_ack=1 at cycle M:
  - At the M+1 edge: m_req←0; the requester's rdata←m_rdata (loads and fetches; d_rdata is unchanged on stores); its valid←1; state←RESP.
- RESP lasts exactly one cycle:
  - valid drops to 0 and state goes to IDLE.
  - No grant is made in RESP; the requester deasserts req during RESP, which prevents a duplicate grant.
- Minimum turnaround with zero-wait memory: grant edge N, m_ack in N+1, valid in N+2, next grant at the N+3 edge.
- Wait counter:
  - Clears on entry to BUSY and increments each BUSY cycle without m_ack.
  - When it reaches MAX_WAIT: err←1 (sticky until reset), m_req←0, valid pulses with rdata←0, state←RESP.
  - m_ack arriving in the same cycle as the timeout takes precedence: normal completion, no error.
- Requester drops req while its transaction is in BUSY (e.g. fetch flushed):
  - The transaction still completes and the valid pulse is still issued; the requester ignores it.
  - stall_* follows its equation.
- if_req and d_req rising in the same IDLE cycle: data wins unless the starve limit has been reached.
- Writes: m_rdata is ignored; d_valid marks write completion.
- Never assert if_valid and d_valid in the same cycle.

Test Plan:
1. Reset then idle: rst=0 for 3 cycles, then rst=1 → all outputs 0, stall_IF=0, stall_MEM=0, m_req stays 0.
2. Single fetch, zero-wait memory:
   - Stimulus: if_req=1, if_addr=0x100, memory acks in the first m_req cycle with m_rdata=0x00500093.
   - Required: m_req=1 for 1 cycle with m_addr=0x100 and m_we=0; if_valid pulses 1 cycle later with if_rdata=0x00500093; stall_IF=1 until that pulse.
3. Simultaneous requests:
   - Stimulus: if_req and d_req (load, addr 0x2000) together, memory 2-wait-state.
   - Required: data is granted first, d_valid then if_valid, m_addr sequence 0x2000 then fetch address, no overlap of m_req transactions.
4. Starvation guard:
   - Stimulus: d_req held high continuously and re-requested after each d_valid, with if_req held high.
   - Required: fetch is granted after exactly 4 data grants; the starve counter then clears.
5. Timeout:
   - Stimulus: data request, m_ack never asserted.
   - Required: after 255 BUSY cycles, err=1, d_valid pulses with d_rdata=0, FSM returns to IDLE; err stays 1 until rst=0.
6. Reset mid-transaction:
   - Stimulus: rst=0 while in BUSY_D with the write still pending.
   - Required: m_req=0 immediately (asynchronous); no d_valid pulse after reset is released.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//
// Shares one single-ported unified memory between the instruction fetch path
// and the MEM-stage load/store path of the 5-stage pipeline. One requester is
// granted at a time and drives a variable-latency req/ack memory port. Read
// data comes back with a one-cycle valid pulse. Data accesses have priority,
// but a starvation guard makes sure fetch is granted after STARVE_LIM
// back-to-back data grants while fetch is waiting.
//
// Ports:
//   clk, rst                  clock (rising edge), async active-low reset
//   if_req/if_addr            fetch request, held until if_valid
//   if_rdata/if_valid         fetched instruction and one-cycle done pulse
//   d_req/d_we/d_addr/
//   d_wdata/d_be              load/store request, held until d_valid
//   d_rdata/d_valid           load data and one-cycle done pulse
//   m_req/m_we/m_addr/
//   m_wdata/m_be              registered memory request port
//   m_ack/m_rdata             memory completion and read data
//   stall_IF/stall_MEM        hazard-unit stalls (combinational)
//   err                       sticky timeout flag

module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_LIM = 4,
    parameter int MAX_WAIT   = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic [DATA_W-1:0]   if_rdata,
    output logic                if_valid,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_be,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                d_valid,
    output logic                m_req,
    output logic                m_we,
    output logic [ADDR_W-1:0]   m_addr,
    output logic [DATA_W-1:0]   m_wdata,
    output logic [DATA_W/8-1:0] m_be,
    input  logic                m_ack,
    input  logic [DATA_W-1:0]   m_rdata,
    output logic                stall_IF,
    output logic                stall_MEM,
    output logic                err
);

    localparam int BE_W = DATA_W / 8;
    localparam int SC_W = $clog2(STARVE_LIM + 1);
    localparam int WC_W = $clog2(MAX_WAIT + 1);

    localparam logic [SC_W-1:0] STARVE_MAX = SC_W'(STARVE_LIM);
    // The timeout fires on the MAX_WAIT-th BUSY cycle without an ack.
    localparam logic [WC_W-1:0] WAIT_LAST  = WC_W'(MAX_WAIT - 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY_IF,
        BUSY_D,
        RESP
    } state_t;

    state_t            state_q, state_d;
    logic              m_req_q, m_req_d;
    logic              m_we_q, m_we_d;
    logic [ADDR_W-1:0] m_addr_q, m_addr_d;
    logic [DATA_W-1:0] m_wdata_q, m_wdata_d;
    logic [BE_W-1:0]   m_be_q, m_be_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              if_valid_q, if_valid_d;
    logic              d_valid_q, d_valid_d;
    logic              err_q, err_d;
    logic [SC_W-1:0]   starve_q, starve_d;
    logic [WC_W-1:0]   wait_q, wait_d;

    // Next-state logic: grant decision in IDLE, completion/timeout in BUSY,
    // and a single RESP cycle so the requester can drop its req before the
    // arbiter looks at it again.
    always_comb begin
        state_d    = state_q;
        m_req_d    = m_req_q;
        m_we_d     = m_we_q;
        m_addr_d   = m_addr_q;
        m_wdata_d  = m_wdata_q;
        m_be_d     = m_be_q;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;
        if_valid_d = 1'b0;
        d_valid_d  = 1'b0;
        err_d      = err_q;
        starve_d   = starve_q;
        wait_d     = wait_q;

        case (state_q)
            IDLE: begin
                // Data wins unless fetch has been waiting through STARVE_LIM data grants.
                if (d_req && !(if_req && (starve_q == STARVE_MAX))) begin
                    state_d   = BUSY_D;
                    m_req_d   = 1'b1;
                    m_we_d    = d_we;
                    m_addr_d  = d_addr;
                    m_wdata_d = d_wdata;
                    m_be_d    = d_be;
                    wait_d    = '0;
                    if (if_req) begin
                        if (starve_q != STARVE_MAX) begin
                            starve_d = starve_q + 1'b1;
                        end
                    end else begin
                        starve_d = '0;
                    end
                end else if (if_req) begin
                    state_d  = BUSY_IF;
                    m_req_d  = 1'b1;
                    m_we_d   = 1'b0;
                    m_addr_d = if_addr;
                    m_be_d   = '1;
                    wait_d   = '0;
                    starve_d = '0;
                end
            end

            BUSY_IF, BUSY_D: begin
                // An ack in the timeout cycle still counts as a normal completion.
                if (m_ack) begin
                    m_req_d = 1'b0;
                    state_d = RESP;
                    if (state_q == BUSY_IF) begin
                        if_rdata_d = m_rdata;
                        if_valid_d = 1'b1;
                    end else begin
                        if (!m_we_q) begin
                            d_rdata_d = m_rdata;
                        end
                        d_valid_d = 1'b1;
                    end
                end else if (wait_q == WAIT_LAST) begin
                    err_d   = 1'b1;
                    m_req_d = 1'b0;
                    state_d = RESP;
                    if (state_q == BUSY_IF) begin
                        if_rdata_d = '0;
                        if_valid_d = 1'b1;
                    end else begin
                        d_rdata_d = '0;
                        d_valid_d = 1'b1;
                    end
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end

            RESP: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and registered outputs; reset abandons any in-flight transaction.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            m_req_q    <= 1'b0;
            m_we_q     <= 1'b0;
            m_addr_q   <= '0;
            m_wdata_q  <= '0;
            m_be_q     <= '0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
            if_valid_q <= 1'b0;
            d_valid_q  <= 1'b0;
            err_q      <= 1'b0;
            starve_q   <= '0;
            wait_q     <= '0;
        end else begin
            state_q    <= state_d;
            m_req_q    <= m_req_d;
            m_we_q     <= m_we_d;
            m_addr_q   <= m_addr_d;
            m_wdata_q  <= m_wdata_d;
            m_be_q     <= m_be_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
            if_valid_q <= if_valid_d;
            d_valid_q  <= d_valid_d;
            err_q      <= err_d;
            starve_q   <= starve_d;
            wait_q     <= wait_d;
        end
    end

    assign m_req    = m_req_q;
    assign m_we     = m_we_q;
    assign m_addr   = m_addr_q;
    assign m_wdata  = m_wdata_q;
    assign m_be     = m_be_q;
    assign if_rdata = if_rdata_q;
    assign d_rdata  = d_rdata_q;
    assign if_valid = if_valid_q;
    assign d_valid  = d_valid_q;
    assign err      = err_q;

    assign stall_IF  = if_req & ~if_valid_q;
    assign stall_MEM = d_req & ~d_valid_q;

endmodule
